// File: rtl/vote_gate_checker.sv
// Stimulus driver and response checker for a 3-input voting gate: walks all 8 {a,b,c} vectors
// and compares y against EXPECT_MASK. Define STOP_ON_FAIL_EN to end a run at the first mismatch.
module vote_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECT_MASK   = 8'hE8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        abc_q, abc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        err_q, err_d;
    logic [7:0]        fail_q, fail_d;
    logic              pass_q, pass_d;
    logic              mismatch;

    assign mismatch = (y != EXPECT_MASK[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        abc_d   = abc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    idx_d   = 3'd0;
                    abc_d   = 3'b000;
                    cnt_d   = '0;
                    err_d   = 4'd0;
                    fail_d  = 8'h00;
                    pass_d  = 1'b0;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d         = err_q + 4'd1;
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q == 3'd7) begin
                    state_d = StDone;
`ifdef STOP_ON_FAIL_EN
                end else if (mismatch) begin
                    // Leave a, b, c on the failing vector for inspection.
                    state_d = StDone;
`endif
                end else begin
                    idx_d   = idx_q + 3'd1;
                    abc_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StDone: begin
                // err_q already holds any mismatch recorded in the final check.
                pass_d  = (err_q == 4'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            abc_q   <= 3'b000;
            cnt_q   <= '0;
            err_q   <= 4'd0;
            fail_q  <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign a         = abc_q[2];
    assign b         = abc_q[1];
    assign c         = abc_q[0];
    assign busy      = (state_q == StSettle) || (state_q == StCheck);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_vote_gate_checker.sv
// Directed bench for vote_gate_checker: a behavioural gate model (majority, minority or stuck-0)
// answers the checker; each task runs one scenario and compares against hand-computed values.
module tb_vote_gate_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       y;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    int mode;   // 0 majority, 1 minority, 2 stuck-at-0
    int errors = 0;
    int checks = 0;

`ifdef STOP_ON_FAIL_EN
    localparam int         MinN    = 5;
    localparam logic [3:0] MinErr  = 4'd1;
    localparam logic [7:0] MinFail = 8'h01;
    localparam int         S0N     = 20;
    localparam logic [3:0] S0Err   = 4'd1;
    localparam logic [7:0] S0Fail  = 8'h08;
    localparam logic [2:0] S0Abc   = 3'b011;
`else
    localparam int         MinN    = 40;
    localparam logic [3:0] MinErr  = 4'd8;
    localparam logic [7:0] MinFail = 8'hFF;
    localparam int         S0N     = 40;
    localparam logic [3:0] S0Err   = 4'd4;
    localparam logic [7:0] S0Fail  = 8'hE8;
    localparam logic [2:0] S0Abc   = 3'b111;
`endif

    vote_gate_checker dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .y         (y),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    always_comb begin
        y = 1'b0;
        case (mode)
            0:       y = (a & b) | (a & c) | (b & c);
            1:       y = ~((a & b) | (a & c) | (b & c));
            default: y = 1'b0;
        endcase
    end

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_wait(output int n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({a, b, c, busy, done, pass, err_count, fail_vec} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {a, b, c, busy, done, pass, err_count, fail_vec});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_majority();
        int n;
        mode = 0;
        run_wait(n);
        checks++;
        if (n !== 40) begin errors++; $display("FAIL maj_latency got=%0d want=40", n); end
        checks++;
        if (err_count !== 4'd0 || fail_vec !== 8'h00) begin
            errors++;
            $display("FAIL maj_result err=%0d fv=%h want 0 00", err_count, fail_vec);
        end
        checks++;
        if ({a, b, c} !== 3'b111 || busy !== 1'b0) begin
            errors++;
            $display("FAIL maj_abc_busy abc=%b busy=%b want 111 0", {a, b, c}, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (pass !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL maj_pass pass=%b done=%b want 1 0", pass, done);
        end
    endtask

    task automatic test_minority();
        int n;
        mode = 1;
        run_wait(n);
        checks++;
        if (n !== MinN) begin errors++; $display("FAIL min_latency got=%0d want=%0d", n, MinN); end
        checks++;
        if (err_count !== MinErr || fail_vec !== MinFail) begin
            errors++;
            $display("FAIL min_result err=%0d fv=%h want %0d %h", err_count, fail_vec,
                     MinErr, MinFail);
        end
        @(posedge clk); #1;
        checks++;
        if (pass !== 1'b0) begin errors++; $display("FAIL min_pass got=%b want=0", pass); end
    endtask

    task automatic test_stuck0();
        mode = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < S0N; k++) begin
            checks++;
            if ({a, b, c} !== 3'(k / 5) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL s0_step k=%0d abc=%b busy=%b done=%b want %b 1 0", k, {a, b, c},
                         busy, done, 3'(k / 5));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL s0_done got=%b want=1", done); end
        checks++;
        if (err_count !== S0Err || fail_vec !== S0Fail || {a, b, c} !== S0Abc) begin
            errors++;
            $display("FAIL s0_result err=%0d fv=%h abc=%b want %0d %h %b", err_count, fail_vec,
                     {a, b, c}, S0Err, S0Fail, S0Abc);
        end
        @(posedge clk); #1;
        checks++;
        if (pass !== 1'b0) begin errors++; $display("FAIL s0_pass got=%b want=0", pass); end
    endtask

    task automatic test_restart_ignored();
        int n;
        int dones;
        int dn;
        mode = 0; dones = 0; dn = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 45) begin
            start = (n == 9 || n == 24);
            @(posedge clk); #1;
            n++;
            if (done) begin dones++; dn = n; end
        end
        start = 1'b0;
        checks++;
        if (dones !== 1 || dn !== 40) begin
            errors++;
            $display("FAIL restart_done count=%0d at=%0d want 1 at 40", dones, dn);
        end
        checks++;
        if (err_count !== 4'd0 || fail_vec !== 8'h00 || pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_result err=%0d fv=%h pass=%b want 0 00 1", err_count,
                     fail_vec, pass);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int dones;
        mode = 0; dones = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({a, b, c, busy, done, pass, err_count, fail_vec} !== 18'd0) begin
            errors++;
            $display("FAIL midrst_outputs got=%h want=0",
                     {a, b, c, busy, done, pass, err_count, fail_vec});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
        run_wait(n);
        checks++;
        if (n !== 40 || err_count !== 4'd0 || fail_vec !== 8'h00) begin
            errors++;
            $display("FAIL midrst_rerun n=%0d err=%0d fv=%h want 40 0 00", n, err_count,
                     fail_vec);
        end
        @(posedge clk); #1;
        checks++;
        if (pass !== 1'b1) begin errors++; $display("FAIL midrst_pass got=%b want=1", pass); end
    endtask

    task automatic test_back_to_back();
        int n;
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== MinN) begin errors++; $display("FAIL b2b_first got=%0d want=%0d", n, MinN); end
        mode = 0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || err_count !== 4'd0 || fail_vec !== 8'h00) begin
            errors++;
            $display("FAIL b2b_restart busy=%b err=%0d fv=%h want 1 0 00", busy, err_count,
                     fail_vec);
        end
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 40 || err_count !== 4'd0) begin
            errors++;
            $display("FAIL b2b_second n=%0d err=%0d want 40 0", n, err_count);
        end
        @(posedge clk); #1;
        checks++;
        if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass got=%b want=1", pass); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 0;
        test_reset();
        test_majority();
        test_minority();
        test_stuck0();
        test_restart_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
